// File: rtl/exec_sequencer_if.sv
// Decoder-to-sequencer bundle: instruction decode requests in, program address
// and register-file write gating out.
interface exec_sequencer_if #(
  parameter int PSIZE = 5
);
  logic [2:0]       opcode;
  logic             PCincr;
  logic             PCrelbranch;
  logic [PSIZE-1:0] branch_off;
  logic             w;
  logic             in_valid;
  logic [PSIZE-1:0] PCout;
  logic             wr_en;
  logic             stall;
  logic             in_ack;

  modport master (
    output opcode, PCincr, PCrelbranch, branch_off, w, in_valid,
    input  PCout, wr_en, stall, in_ack
  );

  modport slave (
    input  opcode, PCincr, PCrelbranch, branch_off, w, in_valid,
    output PCout, wr_en, stall, in_ack
  );
endinterface

// File: rtl/exec_sequencer.sv
// picoMIPS execution sequencer: owns the PC, stretches MUL over MUL_CYCLES and
// holds LDI until a fresh operator strobe arrives.
module exec_sequencer #(
  parameter int         PSIZE      = 5,
  parameter int         MUL_CYCLES = 3,
  parameter logic [2:0] OP_MUL     = 3'd3,
  parameter logic [2:0] OP_LDI     = 3'd4
) (
  input logic            clk,
  input logic            reset,
  exec_sequencer_if.slave bus
);

  typedef enum logic [1:0] {RUN, MUL_WAIT, IN_WAIT, IN_RELEASE} state_t;

  localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 2);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [PSIZE-1:0] pc_q, pc_d, pc_step;
  logic             advance;

  // Relative branch wins over increment; the add wraps naturally at PSIZE bits.
  always_comb begin
    pc_step = '0;
    if (bus.PCrelbranch)  pc_step = bus.branch_off;
    else if (bus.PCincr)  pc_step = PSIZE'(1);
    pc_d = advance ? pc_q + pc_step : pc_q;
  end

  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    advance     = 1'b0;
    bus.wr_en   = 1'b0;
    bus.stall   = 1'b0;
    bus.in_ack  = 1'b0;

    unique case (state_q)
      MUL_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d     = cnt_q - 4'd1;
          bus.stall = 1'b1;
        end else begin
          advance   = 1'b1;
          bus.wr_en = bus.w;
          state_d   = RUN;
        end
      end

      IN_WAIT: begin
        if (bus.in_valid) begin
          advance    = 1'b1;
          bus.wr_en  = bus.w;
          bus.in_ack = 1'b1;
          state_d    = IN_RELEASE;
        end else begin
          bus.stall  = 1'b1;
        end
      end

      default: begin  // RUN and IN_RELEASE
        // A strobe that already fed an LDI must drop before another LDI may use it.
        if (state_q == IN_RELEASE && bus.opcode == OP_LDI && bus.in_valid) begin
          bus.stall = 1'b1;
        end else if (bus.opcode == OP_MUL && MUL_CYCLES > 1) begin
          state_d   = MUL_WAIT;
          cnt_d     = MUL_LOAD;
          bus.stall = 1'b1;
        end else if (bus.opcode == OP_LDI) begin
          if (bus.in_valid) begin
            advance    = 1'b1;
            bus.wr_en  = bus.w;
            bus.in_ack = 1'b1;
            state_d    = IN_RELEASE;
          end else begin
            state_d    = IN_WAIT;
            bus.stall  = 1'b1;
          end
        end else begin
          advance   = 1'b1;
          bus.wr_en = bus.w;
          state_d   = RUN;
        end
      end
    endcase

    // Reset aborts the current instruction: no write, no handshake, no stall.
    if (reset) begin
      bus.wr_en  = 1'b0;
      bus.stall  = 1'b0;
      bus.in_ack = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.PCout = pc_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: directed scenarios with literal
// expectations plus a randomized run against an instruction-level model.
module tb_exec_sequencer;

  localparam int         PSIZE      = 5;
  localparam int         MUL_CYCLES = 3;
  localparam logic [2:0] OP_ADD     = 3'd0;
  localparam logic [2:0] OP_MUL     = 3'd3;
  localparam logic [2:0] OP_LDI     = 3'd4;
  localparam logic [2:0] OP_BNE     = 3'd5;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  exec_sequencer_if #(.PSIZE(PSIZE)) bus ();

  exec_sequencer #(
    .PSIZE(PSIZE), .MUL_CYCLES(MUL_CYCLES), .OP_MUL(OP_MUL), .OP_LDI(OP_LDI)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-level model: how long the current instruction has been held,
  // whether the previous completed instruction was an LDI, and whether the
  // strobe has been seen low since then.
  int m_pc       = 0;
  int m_held     = 0;
  bit m_prev_ldi = 1'b0;
  bit m_low_seen = 1'b0;
  bit m_done     = 1'b1;
  bit e_done, e_ack;

  always @(negedge clk) begin
    check("PCout", 32'(bus.PCout), 32'(m_pc));
    if (reset) begin
      check("wr_en_rst", 32'(bus.wr_en), 0);
      check("stall_rst", 32'(bus.stall), 0);
      check("in_ack_rst", 32'(bus.in_ack), 0);
      m_pc = 0; m_held = 0; m_prev_ldi = 1'b0; m_low_seen = 1'b0; m_done = 1'b1;
    end else begin
      e_ack = 1'b0;
      if (bus.opcode == OP_MUL)
        e_done = (m_held + 1 >= MUL_CYCLES);
      else if (bus.opcode == OP_LDI) begin
        e_done = bus.in_valid && !(m_prev_ldi && !m_low_seen);
        e_ack  = e_done;
      end else
        e_done = 1'b1;
      check("stall", 32'(bus.stall), 32'(!e_done));
      check("wr_en", 32'(bus.wr_en), 32'(e_done && bus.w));
      check("in_ack", 32'(bus.in_ack), 32'(e_ack));
      if (e_done) begin
        if (bus.PCrelbranch)  m_pc = (m_pc + int'(bus.branch_off)) % 32;
        else if (bus.PCincr)  m_pc = (m_pc + 1) % 32;
        m_held     = 0;
        m_prev_ldi = (bus.opcode == OP_LDI);
        m_low_seen = 1'b0;
      end else begin
        m_held++;
      end
      if (!bus.in_valid) m_low_seen = 1'b1;
      m_done = e_done;
    end
  end

  task automatic drive(input logic [2:0] op, input bit w, input bit incr, input bit rel,
                       input logic [PSIZE-1:0] off, input bit iv);
    bus.opcode = op; bus.w = w; bus.PCincr = incr; bus.PCrelbranch = rel;
    bus.branch_off = off; bus.in_valid = iv;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int acks;
  logic [2:0] cur_op;

  initial begin
    // 1: reset with PCincr held, then ADD stream
    drive(OP_ADD, 1, 1, 0, '0, 0);
    check("t1_rst_pc", 32'(bus.PCout), 0);
    tick(); drive(OP_ADD, 1, 1, 0, '0, 0);
    check("t1_rst_wr", 32'(bus.wr_en), 0);
    check("t1_rst_stall", 32'(bus.stall), 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(OP_ADD, 1, 1, 0, '0, 0);
      check("t1_pc", 32'(bus.PCout), 32'(i));
      check("t1_wr", 32'(bus.wr_en), 1);
      tick();
    end

    // 2: MUL at PC=4
    drive(OP_MUL, 1, 1, 0, '0, 0);
    check("t2_pc", 32'(bus.PCout), 4);
    check("t2_stall1", 32'(bus.stall), 1);
    check("t2_wr1", 32'(bus.wr_en), 0);
    tick(); drive(OP_MUL, 1, 1, 0, '0, 0);
    check("t2_stall2", 32'(bus.stall), 1);
    check("t2_wr2", 32'(bus.wr_en), 0);
    tick(); drive(OP_MUL, 1, 1, 0, '0, 0);
    check("t2_stall3", 32'(bus.stall), 0);
    check("t2_wr3", 32'(bus.wr_en), 1);
    tick();
    check("t2_pc_after", 32'(bus.PCout), 5);

    // 3: LDI at PC=2 waiting 5 cycles for the strobe
    reset = 1'b1; drive(OP_ADD, 0, 0, 0, '0, 0); tick();
    reset = 1'b0;
    repeat (2) begin drive(OP_ADD, 1, 1, 0, '0, 0); tick(); end
    check("t3_pc", 32'(bus.PCout), 2);
    for (int i = 0; i < 5; i++) begin
      drive(OP_LDI, 1, 1, 0, '0, 0);
      check("t3_stall", 32'(bus.stall), 1);
      check("t3_ack0", 32'(bus.in_ack), 0);
      tick();
    end
    drive(OP_LDI, 1, 1, 0, '0, 1);
    check("t3_stall_end", 32'(bus.stall), 0);
    check("t3_ack", 32'(bus.in_ack), 1);
    check("t3_wr", 32'(bus.wr_en), 1);
    tick();
    check("t3_pc_after", 32'(bus.PCout), 3);

    // 4: back-to-back LDI with the strobe held high
    drive(OP_ADD, 0, 1, 0, '0, 1); tick();
    acks = 0;
    drive(OP_LDI, 1, 1, 0, '0, 1); acks += int'(bus.in_ack); tick();
    for (int i = 0; i < 3; i++) begin
      drive(OP_LDI, 1, 1, 0, '0, 1);
      check("t4_hold_stall", 32'(bus.stall), 1);
      acks += int'(bus.in_ack);
      tick();
    end
    drive(OP_LDI, 1, 1, 0, '0, 0);
    check("t4_low_stall", 32'(bus.stall), 1);
    acks += int'(bus.in_ack); tick();
    drive(OP_LDI, 1, 1, 0, '0, 1);
    acks += int'(bus.in_ack); tick();
    check("t4_acks", 32'(acks), 2);
    check("t4_pc", 32'(bus.PCout), 6);

    // 5: branch wrap, increment wrap, branch priority
    reset = 1'b1; drive(OP_ADD, 0, 0, 0, '0, 0); tick();
    reset = 1'b0;
    drive(OP_ADD, 1, 1, 0, '0, 0); tick();
    drive(OP_BNE, 0, 0, 1, 5'b11110, 0); tick();
    check("t5_bwrap", 32'(bus.PCout), 31);
    drive(OP_ADD, 1, 1, 0, '0, 0); tick();
    check("t5_iwrap", 32'(bus.PCout), 0);
    repeat (10) begin drive(OP_ADD, 1, 1, 0, '0, 0); tick(); end
    check("t5_pc10", 32'(bus.PCout), 10);
    drive(OP_BNE, 0, 1, 1, 5'd3, 0); tick();
    check("t5_prio", 32'(bus.PCout), 13);

    // 6: reset during MUL_WAIT with one wait cycle left
    drive(OP_MUL, 1, 1, 0, '0, 0); tick();
    drive(OP_MUL, 1, 1, 0, '0, 0);
    check("t6_wait_stall", 32'(bus.stall), 1);
    reset = 1'b1; #1;
    check("t6_rst_wr", 32'(bus.wr_en), 0);
    tick();
    reset = 1'b0;
    drive(OP_ADD, 1, 0, 0, '0, 0);
    check("t6_pc", 32'(bus.PCout), 0);
    check("t6_stall", 32'(bus.stall), 0);
    check("t6_wr", 32'(bus.wr_en), 1);
    tick();

    // Randomized run: opcode held until the model says the instruction completed
    cur_op = OP_ADD;
    for (int c = 0; c < 3000; c++) begin
      if (m_done) begin
        case ($urandom_range(0, 9))
          0, 1, 2: cur_op = OP_MUL;
          3, 4, 5: cur_op = OP_LDI;
          default: cur_op = 3'($urandom_range(0, 7));
        endcase
      end
      reset = ($urandom_range(0, 149) == 0);
      drive(cur_op, 1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0),
            PSIZE'($urandom),
            ($urandom_range(0, 2) == 0) ? !bus.in_valid : bus.in_valid);
      tick();
    end
    reset = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
